// File: rtl/axi_slv_rchannel.sv
// AXI4 slave read-channel front-end: turns AR requests into arbiter read frames and
// packs 64-bit array words into 256-bit R beats, tagging the burst's final beat with rlast.
module axi_slv_rchannel #(
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_ADDR_WIDTH = 25,
   parameter int LEN_FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      axi_s_arvalid,
   output logic                      axi_s_arready,
   input  logic [7:0]                axi_s_arlen,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_s_araddr,
   output logic                      axi_s_rvalid,
   output logic                      axi_s_rlast,
   output logic [AXI_DATA_WIDTH-1:0] axi_s_rdata,
   output logic                      axi2arb_rframe_valid,
   input  logic                      axi2arb_rframe_ready,
   output logic [AXI_ADDR_WIDTH+71:0] axi2arb_rframe_data,
   input  logic                      array_rdata_valid,
   input  logic [63:0]               array_rdata
);

   localparam int PTR_W  = $clog2(LEN_FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PACK_W = AXI_DATA_WIDTH - 64;

   logic                      r_ar_en;
   logic                      r_rframe_valid;
   logic [AXI_ADDR_WIDTH+71:0] r_rframe_data;
   logic [7:0]                r_len_mem [LEN_FIFO_DEPTH];
   logic [PTR_W-1:0]          r_wptr;
   logic [PTR_W-1:0]          r_rptr;
   logic [CNT_W-1:0]          r_count;
   logic [1:0]                r_word_cnt;
   logic [PACK_W-1:0]         r_pack;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;
   logic                      r_rvalid;
   logic                      r_rlast;
   logic [7:0]                r_beat;

   logic       w_full;
   logic       w_empty;
   logic       w_arready;
   logic       w_ar_hs;
   logic       w_frame_hs;
   logic [7:0] w_head_len;
   logic       w_word_ok;
   logic       w_beat_done;
   logic       w_last;

   assign w_full      = (r_count == CNT_W'(LEN_FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_frame_hs  = r_rframe_valid && axi2arb_rframe_ready;
   // r_ar_en keeps arready low while in reset so every output reads 0 there.
   assign w_arready   = r_ar_en && !w_full && (!r_rframe_valid || axi2arb_rframe_ready);
   assign w_ar_hs     = axi_s_arvalid && w_arready;
   assign w_head_len  = r_len_mem[r_rptr];
   assign w_word_ok   = array_rdata_valid && !w_empty;
   assign w_beat_done = w_word_ok && (r_word_cnt == 2'd3);
   assign w_last      = w_beat_done && (r_beat == w_head_len);

   assign axi_s_arready        = w_arready;
   assign axi_s_rvalid         = r_rvalid;
   assign axi_s_rlast          = r_rlast;
   assign axi_s_rdata          = r_rdata;
   assign axi2arb_rframe_valid = r_rframe_valid;
   assign axi2arb_rframe_data  = r_rframe_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ar_en <= 1'b0;
      end else begin
         r_ar_en <= 1'b1;
      end
   end

   // A frame stays posted until the arbiter takes it; a same-cycle AR reloads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rframe_valid <= 1'b0;
         r_rframe_data  <= '0;
      end else if (w_ar_hs) begin
         r_rframe_valid <= 1'b1;
         r_rframe_data  <= {1'b0, axi_s_araddr, axi_s_arlen, 63'b0};
      end else if (w_frame_hs) begin
         r_rframe_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < LEN_FIFO_DEPTH; i++) begin
            r_len_mem[i] <= '0;
         end
      end else begin
         if (w_ar_hs) begin
            r_len_mem[r_wptr] <= axi_s_arlen;
            r_wptr            <= r_wptr + PTR_W'(1);
         end
         if (w_last) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_ar_hs, w_last})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Words 0..2 collect in a shadow register so rdata only changes when a beat is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt <= '0;
         r_pack     <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_rlast    <= 1'b0;
         r_beat     <= '0;
      end else begin
         r_rvalid <= w_beat_done;
         r_rlast  <= w_last;
         if (w_word_ok) begin
            r_word_cnt <= r_word_cnt + 2'd1;
         end
         if (w_word_ok && !w_beat_done) begin
            r_pack <= {array_rdata, r_pack[PACK_W-1:64]};
         end
         if (w_beat_done) begin
            r_rdata <= {array_rdata, r_pack};
            r_beat  <= w_last ? 8'd0 : r_beat + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_slv_rchannel.sv
// Scoreboard bench for axi_slv_rchannel: frames and R beats are predicted as stimulus
// is driven and compared as the DUT emits them.
module tb_axi_slv_rchannel;

   typedef struct packed {
      logic         last;
      logic [255:0] data;
   } beat_t;

   logic         clk;
   logic         rst_n;
   logic         arvalid;
   logic         arready;
   logic [7:0]   arlen;
   logic [24:0]  araddr;
   logic         rvalid;
   logic         rlast;
   logic [255:0] rdata;
   logic         frameValid;
   logic         frameReady;
   logic [96:0]  frameData;
   logic         arrayValid;
   logic [63:0]  arrayData;

   int total = 0;
   int bad   = 0;
   int beatsSeen = 0;
   int lastsSeen = 0;
   int wordSeq   = 0;

   logic [96:0] frameQ[$];
   beat_t       beatQ[$];
   logic [7:0]  lenQ[$];
   logic [63:0] mWords[4];
   int          mCnt  = 0;
   int          mBeat = 0;

   axi_slv_rchannel dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .axi_s_arvalid        (arvalid),
      .axi_s_arready        (arready),
      .axi_s_arlen          (arlen),
      .axi_s_araddr         (araddr),
      .axi_s_rvalid         (rvalid),
      .axi_s_rlast          (rlast),
      .axi_s_rdata          (rdata),
      .axi2arb_rframe_valid (frameValid),
      .axi2arb_rframe_ready (frameReady),
      .axi2arb_rframe_data  (frameData),
      .array_rdata_valid    (arrayValid),
      .array_rdata          (arrayData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (frameValid && frameReady) begin
            if (frameQ.size() == 0) begin
               checkOutput("frame_unexpected", 256'(frameData), 256'd0);
            end else begin
               checkOutput("frame_data", 256'(frameData), 256'(frameQ.pop_front()));
            end
         end
         if (rvalid) begin
            beatsSeen++;
            if (rlast) lastsSeen++;
            if (beatQ.size() == 0) begin
               checkOutput("beat_unexpected", rdata, 256'd0);
            end else begin
               beat_t exp;
               exp = beatQ.pop_front();
               checkOutput("beat_data", rdata, exp.data);
               checkOutput("beat_last", 256'(rlast), 256'(exp.last));
            end
         end else if (rlast) begin
            checkOutput("rlast_without_rvalid", 256'(rlast), 256'd0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake.
   task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] len);
      int n;
      arvalid = 1'b1;
      araddr  = addr;
      arlen   = len;
      n = 0;
      while (!arready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!arready) begin
         checkOutput("ar_timeout", 256'd0, 256'd1);
         arvalid = 1'b0;
      end else begin
         frameQ.push_back({1'b0, addr, len, 63'b0});
         lenQ.push_back(len);
         @(negedge clk);
         arvalid = 1'b0;
      end
   endtask

   task automatic sendWord(input logic [63:0] w);
      arrayValid = 1'b1;
      arrayData  = w;
      if (lenQ.size() != 0) begin
         mWords[mCnt] = w;
         mCnt++;
         if (mCnt == 4) begin
            beat_t b;
            b.data = {mWords[3], mWords[2], mWords[1], mWords[0]};
            b.last = (mBeat == int'(lenQ[0]));
            beatQ.push_back(b);
            if (b.last) begin
               void'(lenQ.pop_front());
               mBeat = 0;
            end else begin
               mBeat++;
            end
            mCnt = 0;
         end
      end
      @(negedge clk);
      arrayValid = 1'b0;
   endtask

   task automatic sendWords(input int count, input int gap);
      for (int i = 0; i < count; i++) begin
         sendWord({32'hDA7A0000, 32'(wordSeq)});
         wordSeq++;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while ((beatQ.size() != 0 || frameQ.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_beats_left"}, 256'(beatQ.size()), 256'd0);
      checkOutput({tag, "_frames_left"}, 256'(frameQ.size()), 256'd0);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [255:0] packExp;
      rst_n      = 1'b0;
      arvalid    = 1'b0;
      arlen      = '0;
      araddr     = '0;
      frameReady = 1'b1;
      arrayValid = 1'b0;
      arrayData  = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_arready", 256'(arready), 256'd0);
      checkOutput("rst_rvalid", 256'(rvalid), 256'd0);
      checkOutput("rst_rlast", 256'(rlast), 256'd0);
      checkOutput("rst_rdata", rdata, 256'd0);
      checkOutput("rst_frame_valid", 256'(frameValid), 256'd0);
      checkOutput("rst_frame_data", 256'(frameData), 256'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_arready", 256'(arready), 256'd1);

      // A stray word with no outstanding burst must be dropped.
      sendWord(64'hBAD0BAD0BAD0BAD0);
      repeat (2) @(negedge clk);
      checkOutput("stray_no_rvalid", 256'(rvalid), 256'd0);

      applyStimulus(25'd24, 8'd18);
      sendWords(76, 1);
      waitDrain("single");

      applyStimulus(25'd7, 8'd0);
      sendWord(64'hFEED0000000000A0);
      sendWord(64'hFEED0000000000A1);
      sendWord(64'hFEED0000000000A2);
      sendWord(64'hFEED0000000000A3);
      waitDrain("pack");
      repeat (3) @(negedge clk);
      packExp = {64'hFEED0000000000A3, 64'hFEED0000000000A2,
                 64'hFEED0000000000A1, 64'hFEED0000000000A0};
      checkOutput("pack_hold", rdata, packExp);

      applyStimulus(25'd24, 8'd18);
      applyStimulus(25'd40, 8'd36);
      sendWords(224, 0);
      waitDrain("b2b");

      frameReady = 1'b0;
      applyStimulus(25'd100, 8'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_frame_valid", 256'(frameValid), 256'd1);
         checkOutput("bp_frame_data", 256'(frameData), 256'({1'b0, 25'd100, 8'd0, 63'b0}));
         checkOutput("bp_arready", 256'(arready), 256'd0);
         @(negedge clk);
      end
      frameReady = 1'b1;
      @(negedge clk);
      applyStimulus(25'd200, 8'd1);
      sendWords(12, 0);
      waitDrain("bp");

      applyStimulus(25'd300, 8'd0);
      applyStimulus(25'd301, 8'd1);
      applyStimulus(25'd302, 8'd2);
      applyStimulus(25'd303, 8'd3);
      checkOutput("full_arready", 256'(arready), 256'd0);
      sendWords(4, 0);
      checkOutput("len0_rvalid", 256'(rvalid), 256'd1);
      checkOutput("len0_rlast", 256'(rlast), 256'd1);
      checkOutput("after_pop_arready", 256'(arready), 256'd1);
      sendWords(36, 1);
      waitDrain("full");

      repeat (4) @(negedge clk);
      checkOutput("beats_total", 256'(beatsSeen), 256'd89);
      checkOutput("rlast_total", 256'(lastsSeen), 256'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
